key_event_decoder: RTL and testbench

Converts the byte stream from the keyboard receiver into the four held key levels (key0..key3) consumed by the arpeggiator and voice logic. It tracks make codes, break prefixes (0xF0) and extended prefixes (0xE0), and suppresses typematic repeats. It also emits one-cycle press and release pulses with the key index.

---
 rtl/synth_pkg.sv | 23 ++
 rtl/key_event_decoder_if.sv | 33 +++
 rtl/prefix_timer.sv | 30 +++
 rtl/key_event_decoder.sv | 120 ++++++++++++
 tb/tb_key_event_decoder.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/synth_pkg.sv
// Shared definitions for the keyboard front end.
// Contents:
//   kev_state_t     - prefix-tracking state of the key event decoder
//   SC_BREAK/SC_EXT - scancode set 2 break and extended prefixes
//   SC_KEY0..3      - default scancodes for the four playable keys (A S D F)
package synth_pkg;

   typedef enum logic [1:0] {
      Idle   = 2'd0,
      Brk    = 2'd1,
      Ext    = 2'd2,
      ExtBrk = 2'd3
   } kev_state_t;

   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;

   localparam logic [7:0] SC_KEY0  = 8'h1C;
   localparam logic [7:0] SC_KEY1  = 8'h1B;
   localparam logic [7:0] SC_KEY2  = 8'h23;
   localparam logic [7:0] SC_KEY3  = 8'h2B;

endpackage

// File: rtl/key_event_decoder_if.sv
// Bundle between the keyboard receiver side and the key event decoder.
// Signals:
//   data_in/data_valid - received scancode byte and its one-cycle strobe
//   panic              - synchronous all-notes-off request
//   key0..key3         - held key levels
//   press_pulse        - one cycle on a key going down
//   release_pulse      - one cycle on a key going up
//   event_idx          - key index belonging to the current pulse
// Modports: master drives bytes/panic and observes keys; slave is the decoder.
interface key_event_decoder_if;

   logic [7:0] data_in;
   logic       data_valid;
   logic       panic;
   logic       key0;
   logic       key1;
   logic       key2;
   logic       key3;
   logic       press_pulse;
   logic       release_pulse;
   logic [1:0] event_idx;

   modport master (
      output data_in, data_valid, panic,
      input  key0, key1, key2, key3, press_pulse, release_pulse, event_idx
   );

   modport slave (
      input  data_in, data_valid, panic,
      output key0, key1, key2, key3, press_pulse, release_pulse, event_idx
   );

endinterface

// File: rtl/prefix_timer.sv
// Abandon timer for a partially received scancode prefix.
// Ports:
//   CLK, RESET - clock and asynchronous active-high reset
//   clr        - restart the count from zero (has priority over en)
//   en         - advance the count by one
//   expired    - count has reached TIMEOUT-1
module prefix_timer #(
   parameter logic [15:0] TIMEOUT = 16'd50000
) (
   input  logic CLK,
   input  logic RESET,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [15:0] count;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en)
         count <= count + 16'd1;
   end

   assign expired = (count == (TIMEOUT - 16'd1));

endmodule

// File: rtl/key_event_decoder.sv
// Turns the receiver's scancode byte stream into four held key levels plus
// one-cycle press/release pulses tagged with the key index. Break (F0) and
// extended (E0) prefixes are tracked; extended keys are never mapped and
// typematic repeats of a held key are swallowed.
// Ports:
//   CLK, RESET - clock and asynchronous active-high reset
//   bus        - slave side of key_event_decoder_if (bytes, panic, key outputs)
module key_event_decoder
   import synth_pkg::*;
#(
   parameter logic [7:0]  CODE0   = SC_KEY0,
   parameter logic [7:0]  CODE1   = SC_KEY1,
   parameter logic [7:0]  CODE2   = SC_KEY2,
   parameter logic [7:0]  CODE3   = SC_KEY3,
   parameter logic [15:0] TIMEOUT = 16'd50000
) (
   input  logic                 CLK,
   input  logic                 RESET,
   key_event_decoder_if.slave   bus
);

   kev_state_t state, state_nxt;
   logic [3:0] keys, keys_nxt;
   logic       press, press_nxt;
   logic       rel, rel_nxt;
   logic [1:0] idx, idx_nxt;
   logic       expired;
   logic       hit;
   logic [1:0] hidx;

   // {hit, index}; an if-chain so the lowest index wins on duplicate codes
   function automatic logic [2:0] code_lookup(input logic [7:0] b);
      if (b == CODE0)      return 3'b100;
      else if (b == CODE1) return 3'b101;
      else if (b == CODE2) return 3'b110;
      else if (b == CODE3) return 3'b111;
      else                 return 3'b000;
   endfunction

   assign {hit, hidx} = code_lookup(bus.data_in);

   // Every accepted byte restarts the abandon window; a panic byte is
   // dropped, but the FSM returns to Idle where the count is irrelevant.
   prefix_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .CLK     (CLK),
      .RESET   (RESET),
      .clr     (bus.data_valid),
      .en      (state != Idle),
      .expired (expired)
   );

   always_comb begin
      state_nxt = state;
      keys_nxt  = keys;
      press_nxt = 1'b0;
      rel_nxt   = 1'b0;
      idx_nxt   = idx;
      if (bus.panic) begin
         state_nxt = Idle;
         keys_nxt  = '0;
      end else if (bus.data_valid) begin
         case (state)
            Idle: begin
               if (bus.data_in == SC_BREAK)
                  state_nxt = Brk;
               else if (bus.data_in == SC_EXT)
                  state_nxt = Ext;
               else if (hit && !keys[hidx]) begin
                  keys_nxt[hidx] = 1'b1;
                  press_nxt      = 1'b1;
                  idx_nxt        = hidx;
               end
            end
            Brk: begin
               if (hit && keys[hidx]) begin
                  keys_nxt[hidx] = 1'b0;
                  rel_nxt        = 1'b1;
                  idx_nxt        = hidx;
               end
               state_nxt = Idle;
            end
            Ext: begin
               state_nxt = (bus.data_in == SC_BREAK) ? ExtBrk : Idle;
            end
            ExtBrk: begin
               state_nxt = Idle;
            end
            default: state_nxt = Idle;
         endcase
      end else if (expired && state != Idle) begin
         // prefix abandoned: fall back without touching any key
         state_nxt = Idle;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= Idle;
         keys  <= '0;
         press <= 1'b0;
         rel   <= 1'b0;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         keys  <= keys_nxt;
         press <= press_nxt;
         rel   <= rel_nxt;
         idx   <= idx_nxt;
      end
   end

   assign bus.key0          = keys[0];
   assign bus.key1          = keys[1];
   assign bus.key2          = keys[2];
   assign bus.key3          = keys[3];
   assign bus.press_pulse   = press;
   assign bus.release_pulse = rel;
   assign bus.event_idx     = idx;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with a short prefix timeout.
module tb_key_event_decoder;

   localparam logic [15:0] TMO = 16'd8;

   logic CLK;
   logic RESET;
   int   tests;
   int   fails;
   int   press_cnt;
   int   rel_cnt;
   int   p0;
   int   r0;

   key_event_decoder_if bus();

   key_event_decoder #(.TIMEOUT(TMO)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   wire [3:0] keys = {bus.key3, bus.key2, bus.key1, bus.key0};

   // pulses are one cycle wide, so each is seen on exactly one falling edge
   initial begin
      press_cnt = 0;
      rel_cnt   = 0;
   end
   always @(negedge CLK) begin
      if (bus.press_pulse === 1'b1)   press_cnt = press_cnt + 1;
      if (bus.release_pulse === 1'b1) rel_cnt   = rel_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests = tests + 1;
      if (got !== exp) begin
         fails = fails + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // byte is presented k falling edges from now and sampled on the following rising edge
   task automatic send_late(input logic [7:0] b, input int k);
      repeat (k) @(negedge CLK);
      bus.data_in    = b;
      bus.data_valid = 1'b1;
      @(negedge CLK);
      bus.data_valid = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_late(b, 1);
   endtask

   task automatic tick();
      @(negedge CLK);
   endtask

   initial begin
      tests          = 0;
      fails          = 0;
      RESET          = 1'b1;
      bus.data_in    = 8'h00;
      bus.data_valid = 1'b0;
      bus.panic      = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_keys", keys, 4'b0000);
      chk("rst_press", bus.press_pulse, 1'b0);
      chk("rst_rel", bus.release_pulse, 1'b0);
      chk("rst_idx", bus.event_idx, 2'd0);
      RESET = 1'b0;
      tick();

      // basic make / break of key0
      send_byte(8'h1C);
      chk("make0_keys", keys, 4'b0001);
      chk("make0_press", bus.press_pulse, 1'b1);
      chk("make0_idx", bus.event_idx, 2'd0);
      tick();
      chk("make0_pulse_width", bus.press_pulse, 1'b0);
      send_byte(8'hF0);
      chk("brk_prefix_keys", keys, 4'b0001);
      send_byte(8'h1C);
      chk("brk0_keys", keys, 4'b0000);
      chk("brk0_rel", bus.release_pulse, 1'b1);
      chk("brk0_idx", bus.event_idx, 2'd0);

      // typematic repeats on key2
      tick();
      p0 = press_cnt;
      r0 = rel_cnt;
      send_byte(8'h23);
      chk("rep_idx", bus.event_idx, 2'd2);
      send_byte(8'h23);
      send_byte(8'h23);
      tick();
      chk("rep_keys", keys, 4'b0100);
      chk("rep_press_cnt", press_cnt - p0, 1);
      send_byte(8'hF0);
      send_byte(8'h23);
      chk("rep_brk_rel", bus.release_pulse, 1'b1);
      chk("rep_brk_idx", bus.event_idx, 2'd2);
      tick();
      chk("rep_brk_keys", keys, 4'b0000);
      chk("rep_rel_cnt", rel_cnt - r0, 1);

      // extended make and extended break are ignored
      p0 = press_cnt;
      r0 = rel_cnt;
      send_byte(8'hE0);
      send_byte(8'h1C);
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h1C);
      tick();
      chk("ext_keys", keys, 4'b0000);
      chk("ext_press_cnt", press_cnt - p0, 0);
      chk("ext_rel_cnt", rel_cnt - r0, 0);
      send_byte(8'h1C);
      chk("ext_idle_make", keys, 4'b0001);
      send_byte(8'hF0);
      send_byte(8'h1C);
      chk("ext_idle_clear", keys, 4'b0000);

      // break prefix abandoned: byte one cycle past the window is a make
      send_byte(8'hF0);
      send_late(8'h1B, TMO);
      chk("tmo_make_keys", keys, 4'b0010);
      chk("tmo_make_press", bus.press_pulse, 1'b1);
      chk("tmo_make_idx", bus.event_idx, 2'd1);
      send_byte(8'hF0);
      send_byte(8'h1B);
      chk("tmo_clear", keys, 4'b0000);

      // byte on the last cycle of the window is still a break
      tick();
      p0 = press_cnt;
      send_byte(8'hF0);
      send_late(8'h1B, TMO - 16'd1);
      tick();
      chk("tmo_edge_keys", keys, 4'b0000);
      chk("tmo_edge_press_cnt", press_cnt - p0, 0);
      send_byte(8'h1B);
      chk("tmo_edge_idle", keys, 4'b0010);
      send_byte(8'hF0);
      send_byte(8'h1B);

      // panic beats a same-cycle make
      send_byte(8'h1C);
      send_byte(8'h2B);
      chk("pan_held", keys, 4'b1001);
      tick();
      p0 = press_cnt;
      r0 = rel_cnt;
      @(negedge CLK);
      bus.data_in    = 8'h1B;
      bus.data_valid = 1'b1;
      bus.panic      = 1'b1;
      @(negedge CLK);
      bus.data_valid = 1'b0;
      bus.panic      = 1'b0;
      chk("pan_keys", keys, 4'b0000);
      chk("pan_press", bus.press_pulse, 1'b0);
      chk("pan_rel", bus.release_pulse, 1'b0);
      tick();
      chk("pan_press_cnt", press_cnt - p0, 0);
      chk("pan_rel_cnt", rel_cnt - r0, 0);

      // reset in the middle of a break sequence discards the prefix
      send_byte(8'hF0);
      @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      chk("mid_rst_keys", keys, 4'b0000);
      send_byte(8'h1C);
      chk("mid_rst_make", keys, 4'b0001);
      chk("mid_rst_press", bus.press_pulse, 1'b1);

      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
